// File: rtl/brick_field_pkg.sv
// Shared definitions for the brick wall: FSM encoding and default field geometry.
// The geometry defaults are shared with the renderer and the collision detector.
package brick_field_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_CLEARED = 2'd2
    } field_state_t;

    localparam int DEF_BRICK_COLS   = 8;
    localparam int DEF_BRICK_ROWS   = 6;
    localparam int DEF_BRICK_W_LOG2 = 6;
    localparam int DEF_BRICK_H_LOG2 = 4;
    localparam int DEF_FIELD_X0     = 64;
    localparam int DEF_FIELD_Y0     = 48;
    localparam int DEF_GAP          = 2;

endpackage

// File: rtl/brick_field_bcd_counter3.sv
// Three-digit BCD counter: increments by one, saturates at 999, synchronous clear.
module bcd_counter3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [11:0] bcd
);

    function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Score register: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bcd <= 12'h000;
        end else if (inc) begin
            bcd <= bcd_inc_sat(bcd);
        end
    end

endmodule

// File: rtl/brick_field.sv
// Brick wall bitmap, per-pixel brick lookup (1-cycle latency), per-frame hit
// removal, BCD score and wall refill.
// Optional feature macro: BRICK_FIELD_ARMOR_EN (armored row-0 bricks need two hits).
module brick_field
    import brick_field_pkg::*;
#(
    parameter int BRICK_COLS   = DEF_BRICK_COLS,
    parameter int BRICK_ROWS   = DEF_BRICK_ROWS,
    parameter int BRICK_W_LOG2 = DEF_BRICK_W_LOG2,
    parameter int BRICK_H_LOG2 = DEF_BRICK_H_LOG2,
    parameter int FIELD_X0     = DEF_FIELD_X0,
    parameter int FIELD_Y0     = DEF_FIELD_Y0,
    parameter int GAP          = DEF_GAP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_pulse,
    input  logic        pixel_valid,
    input  logic [9:0]  pixel_x,
    input  logic [8:0]  pixel_y,
    output logic        brick_px,
    output logic [2:0]  brick_row,
    input  logic        block_collision,
    input  logic        reset_field,
    output logic [6:0]  bricks_left,
    output logic [11:0] score_bcd,
    output logic        level_clear,
`ifdef BRICK_FIELD_ARMOR_EN
    output logic        brick_armored,
`endif
    output logic        fill_busy
);

    localparam int NB      = BRICK_ROWS * BRICK_COLS;
    localparam int IDX_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int CELL_W  = 1 << BRICK_W_LOG2;
    localparam int CELL_H  = 1 << BRICK_H_LOG2;
    localparam int FIELD_W = BRICK_COLS * CELL_W;
    localparam int FIELD_H = BRICK_ROWS * CELL_H;

    field_state_t state, state_n;

    logic [NB-1:0]    bitmap;
    logic [2:0]       fill_row;
    logic             fill_last;
    logic             hit_pending;
    logic [2:0]       hit_row;
    logic [3:0]       hit_col;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_live;
    logic             do_remove;
    logic             do_capture;

    // Pixel lookup, combinational front of stage 1
    logic [31:0]      px32, py32, dx, dy;
    logic             x_in, y_in, x_gap, y_gap, in_field;
    logic [3:0]       col_s;
    logic [2:0]       row_s;
    logic [IDX_W-1:0] idx_s;
    logic             lookup_bit;
    logic             brick_now;
    logic [2:0]       cur_row_p1;
    logic [3:0]       cur_col_p1;

    assign px32     = 32'(pixel_x);
    assign py32     = 32'(pixel_y);
    assign dx       = px32 - 32'(FIELD_X0);
    assign dy       = py32 - 32'(FIELD_Y0);
    assign x_in     = (px32 >= 32'(FIELD_X0)) && (px32 < 32'(FIELD_X0 + FIELD_W));
    assign y_in     = (py32 >= 32'(FIELD_Y0)) && (py32 < 32'(FIELD_Y0 + FIELD_H));
    assign x_gap    = (dx & 32'(CELL_W - 1)) >= 32'(CELL_W - GAP);
    assign y_gap    = (dy & 32'(CELL_H - 1)) >= 32'(CELL_H - GAP);
    assign in_field = pixel_valid && x_in && y_in;
    assign col_s    = 4'(dx >> BRICK_W_LOG2);
    assign row_s    = 3'(dy >> BRICK_H_LOG2);
    assign idx_s    = IDX_W'(32'(row_s) * 32'(BRICK_COLS) + 32'(col_s));
    assign hit_idx  = IDX_W'(32'(hit_row) * 32'(BRICK_COLS) + 32'(hit_col));

    // Bitmap read for the current pixel; out-of-field pixels never index the map.
    always_comb begin
        lookup_bit = 1'b0;
        if (in_field) begin
            lookup_bit = bitmap[idx_s];
        end
    end

    assign brick_now = in_field && !x_gap && !y_gap && lookup_bit && (state == ST_PLAY);

    // ---- stage 1 boundary: registered pixel result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            brick_px  <= 1'b0;
            brick_row <= 3'd0;
        end else begin
            brick_px  <= brick_now;
            brick_row <= brick_now ? row_s : 3'd0;
        end
    end

    // Row/col of the registered pixel, used when a collision is captured.
    always_ff @(posedge clk) begin
        cur_row_p1 <= row_s;
        cur_col_p1 <= col_s;
    end

`ifdef BRICK_FIELD_ARMOR_EN
    logic [BRICK_COLS-1:0] armor;
    logic                  armor_hit;
    logic                  do_strip;

    assign armor_hit = (hit_row == 3'd0) && armor[hit_col];

    // Armor flag aligned with brick_px for renderer shading.
    always_ff @(posedge clk) begin
        if (rst) begin
            brick_armored <= 1'b0;
        end else begin
            brick_armored <= brick_now && (row_s == 3'd0) && armor[col_s];
        end
    end

    // Armor bits: set when row 0 is filled, stripped by the first hit.
    always_ff @(posedge clk) begin
        if (rst || reset_field) begin
            armor <= '0;
        end else if (state == ST_FILL && fill_row == 3'd0) begin
            armor <= '1;
        end else if (do_strip) begin
            armor[hit_col] <= 1'b0;
        end
    end
`endif

    assign fill_last = (fill_row == 3'(BRICK_ROWS - 1));
    assign hit_live  = bitmap[hit_idx];

    // Next-state and per-cycle strobes; reset_field overrides everything.
    always_comb begin
        state_n    = state;
        do_remove  = 1'b0;
        do_capture = 1'b0;
`ifdef BRICK_FIELD_ARMOR_EN
        do_strip   = 1'b0;
`endif
        case (state)
            ST_FILL: begin
                if (fill_last) state_n = ST_PLAY;
            end
            ST_PLAY: begin
                if (frame_pulse) begin
                    if (hit_pending && hit_live) begin
`ifdef BRICK_FIELD_ARMOR_EN
                        if (armor_hit) do_strip = 1'b1; else
`endif
                        begin
                            do_remove = 1'b1;
                            if (bricks_left == 7'd1) state_n = ST_CLEARED;
                        end
                    end
                end else if (!hit_pending && block_collision && brick_px) begin
                    do_capture = 1'b1;
                end
            end
            ST_CLEARED: begin
                if (frame_pulse) state_n = ST_FILL;
            end
            default: state_n = ST_FILL;
        endcase
        if (reset_field) begin
            state_n    = ST_FILL;
            do_remove  = 1'b0;
            do_capture = 1'b0;
`ifdef BRICK_FIELD_ARMOR_EN
            do_strip   = 1'b0;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FILL;
        else     state <= state_n;
    end

    // Wall bitmap, fill counter, live count and hit bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap      <= '0;
            fill_row    <= 3'd0;
            fill_busy   <= 1'b1;
            bricks_left <= 7'd0;
            level_clear <= 1'b0;
            hit_pending <= 1'b0;
        end else begin
            level_clear <= do_remove && (bricks_left == 7'd1);
            if (reset_field) begin
                bitmap      <= '0;
                fill_row    <= 3'd0;
                fill_busy   <= 1'b1;
                bricks_left <= 7'd0;
                hit_pending <= 1'b0;
            end else begin
                case (state)
                    ST_FILL: begin
                        bitmap[32'(fill_row) * BRICK_COLS +: BRICK_COLS] <= '1;
                        if (fill_last) begin
                            fill_row    <= 3'd0;
                            fill_busy   <= 1'b0;
                            bricks_left <= 7'(NB);
                        end else begin
                            fill_row <= fill_row + 3'd1;
                        end
                    end
                    ST_PLAY: begin
                        if (frame_pulse) hit_pending <= 1'b0;
                        if (do_capture)  hit_pending <= 1'b1;
                        if (do_remove) begin
                            bitmap[hit_idx] <= 1'b0;
                            bricks_left     <= bricks_left - 7'd1;
                        end
                    end
                    ST_CLEARED: begin
                        if (frame_pulse) begin
                            fill_busy <= 1'b1;
                            fill_row  <= 3'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Location of the captured brick; only meaningful while hit_pending.
    always_ff @(posedge clk) begin
        if (do_capture) begin
            hit_row <= cur_row_p1;
            hit_col <= cur_col_p1;
        end
    end

    bcd_counter3 u_score (
        .clk (clk),
        .rst (rst),
        .clr (reset_field),
        .inc (do_remove),
        .bcd (score_bcd)
    );

endmodule

// File: tb/tb_brick_field.sv
// Directed self-checking bench for brick_field.
module tb_brick_field;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_pulse = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [8:0]  pixel_y = '0;
    logic        brick_px;
    logic [2:0]  brick_row;
    logic        block_collision = 1'b0;
    logic        reset_field = 1'b0;
    logic [6:0]  bricks_left;
    logic [11:0] score_bcd;
    logic        level_clear;
    logic        fill_busy;
`ifdef BRICK_FIELD_ARMOR_EN
    logic        brick_armored;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    brick_field dut (
        .clk             (clk),
        .rst             (rst),
        .frame_pulse     (frame_pulse),
        .pixel_valid     (pixel_valid),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .brick_px        (brick_px),
        .brick_row       (brick_row),
        .block_collision (block_collision),
        .reset_field     (reset_field),
        .bricks_left     (bricks_left),
        .score_bcd       (score_bcd),
        .level_clear     (level_clear),
`ifdef BRICK_FIELD_ARMOR_EN
        .brick_armored   (brick_armored),
`endif
        .fill_busy       (fill_busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached after %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic query(input int x, input int y);
        pixel_valid = 1'b1;
        pixel_x     = 10'(x);
        pixel_y     = 9'(y);
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic hit_once(input int x, input int y);
        query(x, y);
        block_collision = 1'b1;
        tick();
        block_collision = 1'b0;
        frame_pulse = 1'b1;
        tick();
        frame_pulse = 1'b0;
    endtask

    task automatic clear_brick(input int r, input int c);
`ifdef BRICK_FIELD_ARMOR_EN
        if (r == 0) hit_once(64 + c * 64 + 5, 48 + r * 16 + 3);
`endif
        hit_once(64 + c * 64 + 5, 48 + r * 16 + 3);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL reset_fill_busy: got %0b want 1", fill_busy); end
        checks++; if (bricks_left !== 7'd0) begin errors++; $display("FAIL reset_bricks_left: got %0d want 0", bricks_left); end
        checks++; if (brick_px !== 1'b0 || brick_row !== 3'd0) begin errors++; $display("FAIL reset_px: got %0b/%0d want 0/0", brick_px, brick_row); end
        checks++; if (score_bcd !== 12'h000 || level_clear !== 1'b0) begin errors++; $display("FAIL reset_score: got %h/%0b want 000/0", score_bcd, level_clear); end
        rst = 1'b0;
        repeat (3) tick();
        query(64, 48);
        checks++; if (brick_px !== 1'b0) begin errors++; $display("FAIL fill_px_forced: got %0b want 0", brick_px); end
        tick();
        checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL fill_busy_cycle5: got %0b want 1", fill_busy); end
        tick();
        checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL fill_busy_cycle6: got %0b want 0", fill_busy); end
        checks++; if (bricks_left !== 7'd48) begin errors++; $display("FAIL fill_bricks_left: got %0d want 48", bricks_left); end
    endtask

    task automatic test_pixel;
        int xs[8]  = '{64, 126, 63, 64, 573, 100, 64, 575};
        int ys[8]  = '{48, 48, 48, 144, 125, 70, 62, 48};
        int epx[8] = '{1, 0, 0, 0, 1, 1, 0, 0};
        int erw[8] = '{0, 0, 0, 0, 4, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            query(xs[i], ys[i]);
            checks++;
            if (brick_px !== 1'(epx[i]) || brick_row !== 3'(erw[i])) begin
                errors++;
                $display("FAIL pixel_(%0d,%0d): got px=%0b row=%0d want px=%0d row=%0d", xs[i], ys[i], brick_px, brick_row, epx[i], erw[i]);
            end
        end
        pixel_x = 10'd64; pixel_y = 9'd48; pixel_valid = 1'b0;
        tick();
        checks++; if (brick_px !== 1'b0) begin errors++; $display("FAIL pixel_invalid: got %0b want 0", brick_px); end
    endtask

    task automatic test_hit;
        query(200, 70);
        checks++; if (brick_px !== 1'b1 || brick_row !== 3'd1) begin errors++; $display("FAIL hit_pre: got px=%0b row=%0d want 1/1", brick_px, brick_row); end
        block_collision = 1'b1;
        tick();
        block_collision = 1'b0;
        frame_pulse = 1'b1;
        tick();
        frame_pulse = 1'b0;
        checks++; if (bricks_left !== 7'd47) begin errors++; $display("FAIL hit_bricks_left: got %0d want 47", bricks_left); end
        checks++; if (score_bcd !== 12'h001) begin errors++; $display("FAIL hit_score: got %h want 001", score_bcd); end
        query(200, 70);
        checks++; if (brick_px !== 1'b0) begin errors++; $display("FAIL hit_gone: got %0b want 0", brick_px); end
    endtask

    task automatic test_two_hits;
        query(64, 64);
        checks++; if (brick_px !== 1'b1) begin errors++; $display("FAIL two_first_pre: got %0b want 1", brick_px); end
        block_collision = 1'b1; tick(); block_collision = 1'b0;
        query(300, 64);
        checks++; if (brick_px !== 1'b1) begin errors++; $display("FAIL two_second_pre: got %0b want 1", brick_px); end
        block_collision = 1'b1; tick(); block_collision = 1'b0;
        frame_pulse = 1'b1; tick(); frame_pulse = 1'b0;
        checks++; if (bricks_left !== 7'd46 || score_bcd !== 12'h002) begin errors++; $display("FAIL two_count: got %0d/%h want 46/002", bricks_left, score_bcd); end
        query(64, 64);
        checks++; if (brick_px !== 1'b0) begin errors++; $display("FAIL two_first_removed: got %0b want 0", brick_px); end
        query(300, 64);
        checks++; if (brick_px !== 1'b1) begin errors++; $display("FAIL two_second_kept: got %0b want 1", brick_px); end
    endtask

    task automatic test_same_cycle;
        query(300, 80);
        checks++; if (brick_px !== 1'b1) begin errors++; $display("FAIL same_pre: got %0b want 1", brick_px); end
        block_collision = 1'b1; frame_pulse = 1'b1;
        tick();
        block_collision = 1'b0; frame_pulse = 1'b0;
        tick();
        frame_pulse = 1'b1; tick(); frame_pulse = 1'b0;
        checks++; if (bricks_left !== 7'd46 || score_bcd !== 12'h002) begin errors++; $display("FAIL same_count: got %0d/%h want 46/002", bricks_left, score_bcd); end
        query(300, 80);
        checks++; if (brick_px !== 1'b1) begin errors++; $display("FAIL same_kept: got %0b want 1", brick_px); end
    endtask

    task automatic test_reset_field;
        query(300, 80);
        block_collision = 1'b1; tick(); block_collision = 1'b0;
        reset_field = 1'b1; frame_pulse = 1'b1;
        tick();
        reset_field = 1'b0; frame_pulse = 1'b0;
        checks++; if (bricks_left !== 7'd0 || score_bcd !== 12'h000) begin errors++; $display("FAIL rf_clear: got %0d/%h want 0/000", bricks_left, score_bcd); end
        checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL rf_fill_busy: got %0b want 1", fill_busy); end
        repeat (5) tick();
        checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL rf_fill_cycle5: got %0b want 1", fill_busy); end
        tick();
        checks++; if (fill_busy !== 1'b0 || bricks_left !== 7'd48) begin errors++; $display("FAIL rf_refill: got %0b/%0d want 0/48", fill_busy, bricks_left); end
        query(300, 80);
        checks++; if (brick_px !== 1'b1 || score_bcd !== 12'h000) begin errors++; $display("FAIL rf_no_removal: got %0b/%h want 1/000", brick_px, score_bcd); end
    endtask

    task automatic test_clear_level;
        for (int b = 0; b < 48; b++) begin
            clear_brick(b / 8, b % 8);
            checks++;
            if (level_clear !== (b == 47)) begin errors++; $display("FAIL clear_pulse_b%0d: got %0b want %0b", b, level_clear, (b == 47)); end
        end
        checks++; if (bricks_left !== 7'd0 || score_bcd !== 12'h048) begin errors++; $display("FAIL clear_count: got %0d/%h want 0/048", bricks_left, score_bcd); end
        tick();
        checks++; if (level_clear !== 1'b0) begin errors++; $display("FAIL clear_single_pulse: got %0b want 0", level_clear); end
        query(64, 48);
        checks++; if (brick_px !== 1'b0) begin errors++; $display("FAIL cleared_px: got %0b want 0", brick_px); end
        frame_pulse = 1'b1; tick(); frame_pulse = 1'b0;
        checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL cleared_to_fill: got %0b want 1", fill_busy); end
        repeat (6) tick();
        checks++; if (fill_busy !== 1'b0 || bricks_left !== 7'd48 || score_bcd !== 12'h048) begin errors++; $display("FAIL refill_keep_score: got %0b/%0d/%h want 0/48/048", fill_busy, bricks_left, score_bcd); end
    endtask

    task automatic test_saturate;
        int done = 48;
        int lv = 0;
        while (done < 1000) begin
            clear_brick(lv / 8, lv % 8);
            lv++;
            done++;
            if (done == 100) begin
                checks++; if (score_bcd !== 12'h100) begin errors++; $display("FAIL bcd_carry: got %h want 100", score_bcd); end
            end
            if (done == 999) begin
                checks++; if (score_bcd !== 12'h999) begin errors++; $display("FAIL bcd_999: got %h want 999", score_bcd); end
            end
            if (done == 1000) begin
                checks++; if (score_bcd !== 12'h999) begin errors++; $display("FAIL bcd_saturate: got %h want 999", score_bcd); end
                checks++; if (bricks_left !== 7'(48 - lv)) begin errors++; $display("FAIL sat_bricks_left: got %0d want %0d", bricks_left, 48 - lv); end
            end
            if (lv == 48) begin
                frame_pulse = 1'b1; tick(); frame_pulse = 1'b0;
                repeat (6) tick();
                lv = 0;
            end
        end
    endtask

`ifdef BRICK_FIELD_ARMOR_EN
    task automatic test_armor;
        reset_field = 1'b1; tick(); reset_field = 1'b0;
        repeat (6) tick();
        query(64, 48);
        checks++; if (brick_armored !== 1'b1) begin errors++; $display("FAIL armor_set: got %0b want 1", brick_armored); end
        hit_once(64, 48);
        checks++; if (bricks_left !== 7'd48 || score_bcd !== 12'h000) begin errors++; $display("FAIL armor_first: got %0d/%h want 48/000", bricks_left, score_bcd); end
        query(64, 48);
        checks++; if (brick_px !== 1'b1 || brick_armored !== 1'b0) begin errors++; $display("FAIL armor_stripped: got %0b/%0b want 1/0", brick_px, brick_armored); end
        hit_once(64, 48);
        checks++; if (bricks_left !== 7'd47 || score_bcd !== 12'h001) begin errors++; $display("FAIL armor_second: got %0d/%h want 47/001", bricks_left, score_bcd); end
        query(64, 48);
        checks++; if (brick_px !== 1'b0) begin errors++; $display("FAIL armor_removed: got %0b want 0", brick_px); end
    endtask
`endif

    initial begin
        test_reset();
        test_pixel();
        test_hit();
        test_two_hits();
        test_same_cycle();
        test_reset_field();
        test_clear_level();
        test_saturate();
`ifdef BRICK_FIELD_ARMOR_EN
        test_armor();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
